pixel_serializer: RTL and testbench

Downstream of the colour LUT: takes one batch of NUM_ENGINES RGB values per handshake and emits them one pixel per cycle in raster order on a valid/ready video stream. It also generates start-of-frame and end-of-line markers and a frame-done pulse. It sits between the LUT and the video-out / frame-buffer writer. A batch is NUM_ENGINES horizontally consecutive pixels, with index 0 leftmost.

---
 rtl/mandelbrot_pkg.sv | 22 ++
 rtl/pixel_serializer_if.sv | 27 ++
 rtl/raster_counter.sv | 60 ++++++
 rtl/pixel_serializer.sv | 103 ++++++++++
 tb/tb_pixel_serializer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared defaults and types for the colour LUT and pixel serializer stages.
// Image geometry and batch width live here so both stages agree on them.
package mandelbrot_pkg;

  localparam int RGB_SIZE    = 24;
  localparam int NUM_ENGINES = 12;
  localparam int X_SIZE      = 640;
  localparam int Y_SIZE      = 480;

  typedef logic [RGB_SIZE-1:0] rgb_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } ser_state_e;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_serializer_if.sv
// Batch-in / pixel-out handshake bundle for the serializer.
// master: the serializer itself; slave: its upstream LUT and downstream sink.
interface pixel_serializer_if #(
  parameter int RGB_SIZE    = mandelbrot_pkg::RGB_SIZE,
  parameter int NUM_ENGINES = mandelbrot_pkg::NUM_ENGINES
);

  logic                in_valid;
  logic                in_ready;
  logic [RGB_SIZE-1:0] rgb_in [NUM_ENGINES];
  logic [RGB_SIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_eol;

  modport master (
    input  in_valid, rgb_in, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eol
  );

  modport slave (
    output in_valid, rgb_in, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eol
  );

endinterface

// File: rtl/raster_counter.sv
// Raster x/y position tracker advanced by each pixel transfer.
// Provides raw sof/eol flags for the current position and a registered frame_done pulse.
module raster_counter #(
  parameter int X_SIZE = mandelbrot_pkg::X_SIZE,
  parameter int Y_SIZE = mandelbrot_pkg::Y_SIZE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic xfer,
  output logic sof,
  output logic eol,
  output logic frame_done
);
  import mandelbrot_pkg::*;

  localparam int X_W = cnt_w(X_SIZE);
  localparam int Y_W = cnt_w(Y_SIZE);
  localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           frame_done_q, frame_done_d;
  logic           x_end, y_end;

  assign x_end = (x_q == X_LAST);
  assign y_end = (y_q == Y_LAST);

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    if (xfer) begin
      frame_done_d = x_end && y_end;
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sof        = (x_q == '0) && (y_q == '0);
  assign eol        = x_end;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/pixel_serializer.sv
// Serializes NUM_ENGINES-pixel batches into a one-pixel-per-cycle raster video stream
// with start-of-frame / end-of-line markers and a frame-done pulse.
module pixel_serializer #(
  parameter int RGB_SIZE    = mandelbrot_pkg::RGB_SIZE,
  parameter int NUM_ENGINES = mandelbrot_pkg::NUM_ENGINES,
  parameter int X_SIZE      = mandelbrot_pkg::X_SIZE,
  parameter int Y_SIZE      = mandelbrot_pkg::Y_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pixel_serializer_if.master    bus,
  output logic                  frame_done
);
  import mandelbrot_pkg::*;

  localparam int IDX_W = cnt_w(NUM_ENGINES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);

  ser_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RGB_SIZE-1:0] batch_q [NUM_ENGINES];
  logic [RGB_SIZE-1:0] batch_d [NUM_ENGINES];

  logic in_ready;
  logic out_valid;
  logic last_pix;
  logic accept;
  logic xfer;
  logic sof_raw;
  logic eol_raw;

  assign out_valid = (state_q == ST_SEND);
  assign last_pix  = (idx_q == IDX_LAST);
  // Opening the input on the last pixel lets the next batch land with no bubble.
  assign in_ready  = (state_q == ST_EMPTY) || (bus.out_ready && last_pix);
  assign accept    = bus.in_valid && in_ready;
  assign xfer      = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    batch_d = batch_q;
    if (accept) begin
      batch_d = bus.rgb_in;
    end
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (last_pix) begin
            idx_d   = '0;
            state_d = accept ? ST_SEND : ST_EMPTY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Batch storage carries no reset; out_data is forced to zero whenever nothing is held.
  always_ff @(posedge clk) begin
    batch_q <= batch_d;
  end

  raster_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .xfer       (xfer),
    .sof        (sof_raw),
    .eol        (eol_raw),
    .frame_done (frame_done)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? batch_q[idx_q] : '0;
  assign bus.out_sof   = out_valid && sof_raw;
  assign bus.out_eol   = out_valid && eol_raw;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer on a 24x2 frame with 12-pixel batches.
module tb_pixel_serializer;

  localparam int RGB = 24;
  localparam int NE  = 12;
  localparam int XS  = 24;
  localparam int YS  = 2;

  localparam int MODE_IDLE = 0;
  localparam int MODE_CAP  = 1;
  localparam int MODE_BP   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_done;

  pixel_serializer_if #(.RGB_SIZE(RGB), .NUM_ENGINES(NE)) bus ();

  pixel_serializer #(
    .RGB_SIZE    (RGB),
    .NUM_ENGINES (NE),
    .X_SIZE      (XS),
    .Y_SIZE      (YS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mode    = MODE_IDLE;

  logic [RGB-1:0] q_data [$];
  bit             q_sof  [$];
  bit             q_eol  [$];
  int             q_cyc  [$];
  int             fd_cnt = 0;
  int             fd_cyc = 0;

  logic [RGB-1:0] bp_exp [36];
  int             bp_recv = 0;
  int             bp_acc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Observer: samples at negedge what will transfer on the following rising edge.
  initial begin
    bit mv;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (mode == MODE_CAP && bus.out_valid && bus.out_ready) begin
        q_data.push_back(bus.out_data);
        q_sof.push_back(bus.out_sof);
        q_eol.push_back(bus.out_eol);
        q_cyc.push_back(cyc);
      end
      if (mode == MODE_BP) begin
        mv = (bp_acc > bp_recv);
        chk("bp_valid", 32'(bus.out_valid), 32'(mv));
        if (mv && bp_recv < 36) chk("bp_data", 32'(bus.out_data), 32'(bp_exp[bp_recv]));
        chk("bp_in_ready", 32'(bus.in_ready),
            32'(!mv || (bus.out_ready && (bp_recv % NE) == NE - 1)));
        if (bus.out_valid && bus.out_ready) bp_recv++;
        if (bus.in_valid && bus.in_ready) bp_acc += NE;
      end
    end
  end

  task automatic load_batch(input logic [RGB-1:0] base);
    for (int i = 0; i < NE; i++) bus.rgb_in[i] = base + RGB'(i);
  endtask

  task automatic clear_cap();
    q_data.delete();
    q_sof.delete();
    q_eol.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offers nb batches back to back; batch b holds base + b*step + i.
  task automatic send_stream(input int nb, input logic [RGB-1:0] base,
                             input logic [RGB-1:0] step, input bit rnd);
    int  b;
    bit  adv;
    bit  done;
    b = 0;
    done = 1'b0;
    load_batch(base);
    bus.in_valid = 1'b1;
    for (int g = 0; g < 400 && !done; g++) begin
      @(negedge clk);
      adv = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      if (adv) begin
        b++;
        if (b < nb) load_batch(base + RGB'(b) * step);
        else begin
          bus.in_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
    chk("send_accepts", 32'(b), 32'(nb));
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_pix(input int n, input string tag);
    for (int g = 0; g < 400; g++) begin
      @(negedge clk); #1;
      if (q_data.size() >= n) break;
    end
    chk(tag, 32'(q_data.size()), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    load_batch('0);

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_sof_eol", {30'd0, bus.out_sof, bus.out_eol}, 32'd0);
    #1 rst_n = 1'b1;

    // Single batch 0x000001..0x00000C
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    clear_cap();
    mode = MODE_CAP;
    send_stream(1, 24'h000001, 24'h0, 1'b0);
    wait_pix(NE, "single_count");
    for (int k = 0; k < NE && k < q_data.size(); k++) begin
      chk($sformatf("single_data[%0d]", k), 32'(q_data[k]), 32'(k + 1));
      chk($sformatf("single_sof[%0d]", k), 32'(q_sof[k]), 32'(k == 0));
      chk($sformatf("single_eol[%0d]", k), 32'(q_eol[k]), 32'd0);
      chk($sformatf("single_gap[%0d]", k), 32'(q_cyc[k]), 32'(q_cyc[0] + k));
    end
    @(posedge clk); #1;
    chk("single_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("single_valid_after", 32'(bus.out_valid), 32'd0);

    // Back-to-back: 5 batches, frame of 48 then the start of the next frame
    mode = MODE_IDLE;
    do_reset();
    bus.out_ready = 1'b1;
    clear_cap();
    fd_cnt = 0;
    mode = MODE_CAP;
    send_stream(5, 24'h100000, 24'h000100, 1'b0);
    wait_pix(60, "b2b_count");
    for (int k = 0; k < 60 && k < q_data.size(); k++) begin
      chk($sformatf("b2b_data[%0d]", k), 32'(q_data[k]),
          32'(24'h100000 + (k / NE) * 256 + (k % NE)));
      chk($sformatf("b2b_eol[%0d]", k), 32'(q_eol[k]), 32'(k == 23 || k == 47));
      chk($sformatf("b2b_sof[%0d]", k), 32'(q_sof[k]), 32'(k == 0 || k == 48));
      chk($sformatf("b2b_gap[%0d]", k), 32'(q_cyc[k]), 32'(q_cyc[0] + k));
    end
    chk("b2b_fd_count", 32'(fd_cnt), 32'd1);
    if (q_cyc.size() > 47) chk("b2b_fd_cycle", 32'(fd_cyc), 32'(q_cyc[47] + 1));

    // Backpressure with random out_ready over 3 batches
    @(posedge clk); #1;
    mode = MODE_IDLE;
    for (int k = 0; k < 36; k++) bp_exp[k] = 24'hA00000 + RGB'((k / NE) * 256 + (k % NE));
    bp_recv = 0;
    bp_acc  = 0;
    mode = MODE_BP;
    send_stream(3, 24'hA00000, 24'h000100, 1'b1);
    for (int g = 0; g < 600 && bp_recv < 36; g++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk); #1;
    mode = MODE_IDLE;
    chk("bp_total", 32'(bp_recv), 32'd36);
    bus.out_ready = 1'b1;

    // Reset after 30 pixels of a frame
    do_reset();
    bus.out_ready = 1'b1;
    clear_cap();
    fd_cnt = 0;
    mode = MODE_CAP;
    begin
      int  b;
      bit  adv;
      b = 0;
      load_batch(24'hB00000);
      bus.in_valid = 1'b1;
      for (int g = 0; g < 300; g++) begin
        @(negedge clk);
        adv = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        if (adv) begin
          b++;
          if (b < 3) load_batch(24'hB00000 + RGB'(b) * 24'h100);
          else bus.in_valid = 1'b0;
        end
        if (q_data.size() >= 30) break;
      end
    end
    chk("mid_pixels_before_rst", 32'(q_data.size()), 32'd30);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_sof_eol", {30'd0, bus.out_sof, bus.out_eol}, 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_cap();
    send_stream(1, 24'hC00000, 24'h0, 1'b0);
    wait_pix(NE, "mid_after_count");
    if (q_data.size() >= 2) begin
      chk("mid_after_sof0", 32'(q_sof[0]), 32'd1);
      chk("mid_after_data0", 32'(q_data[0]), 32'h00C00000);
      chk("mid_after_sof1", 32'(q_sof[1]), 32'd0);
      chk("mid_after_data1", 32'(q_data[1]), 32'h00C00001);
    end
    chk("mid_fd_count", 32'(fd_cnt), 32'd0);
    mode = MODE_IDLE;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
